uart_tx_arbiter: RTL and testbench
==================================

Name:
uart_tx_arbiter

Overview:
Shares one uart transmitter between N_REQ independent requesters. Each requester offers byte packets (valid/ready/last).
- The arbiter grants one requester at a time in round-robin order.
- A grant is held for a whole packet.
- Bytes are forwarded to the uart tx_data/wr/busy port.
- A stalled grant holder is evicted after a timeout.
Sits between on-chip message sources (status, echo, debug) and the uart instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT, 1023, idle cycles in SEND before eviction; 0 disables timeout
TW, 10, width of timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  byte offered by requester i
req_data  in  8*N_REQ  byte of requester i at bits [8i+7:8i]
req_last  in  N_REQ  offered byte is last of packet
req_ready  out  N_REQ  byte of requester i accepted this cycle
grant  out  N_REQ  one-hot current owner, 0 when idle
uart_data  out  8  byte to uart tx_data
uart_wr  out  1  write strobe to uart wr
uart_busy  in  1  uart busy; a byte is taken when uart_wr && !uart_busy
evict  out  1  one-cycle pulse: grant revoked by timeout
evict_id  out  3  index of evicted requester, valid with evict

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: state IDLE, grant=0, rr pointer=0, timeout count=0, evict=0, evict_id=0, registered outputs 0.
- req_ready, uart_wr and uart_data are combinational from state and inputs, so they are 0 while in reset.
- States: IDLE, SEND, HOLD.
- IDLE:
  - grant=0; req_ready=0; uart_wr=0.
  - If any req_valid, pick the first set bit searching upward from the rr pointer, with wrap.
  - Next cycle: grant=onehot(winner), pointer=winner+1 mod N_REQ, timeout count cleared, state SEND.
  - Grant latency: 1 cycle from req_valid sampled in IDLE.
- SEND, with owner g:
  - Accept condition: acc = req_valid[g] && !uart_busy.
  - When acc: uart_wr=1, req_ready[g]=1, uart_data=req_data[g]. All are combinational in the same cycle.
  - uart_data is always driven from the owner's slice; it is 0 when idle.
  - On acc: state HOLD; timeout count cleared.
- HOLD:
  - Exactly one cycle with uart_wr=0, covering the uart's one-cycle busy rise.
  - Then: if the accepted byte had req_last[g]=1, go to IDLE and drop grant. Otherwise go to SEND.
  - Minimum spacing between strobes is 2 cycles; back-to-back wr is never issued.
- Timeout (TIMEOUT>0):
  - In SEND, the count increments each cycle req_valid[g]=0.
  - It holds (no increment, no clear) while req_valid[g]=1 && uart_busy.
  - When the count reaches TIMEOUT: evict=1 and evict_id=g for one cycle, grant=0, state IDLE. The byte in flight is unaffected.
  - A requester whose valid merely waits on busy is never evicted.
- Boundary cases:
  - Single-byte packet (last on first byte): SEND, HOLD, IDLE.
  - uart_busy already high at grant: stay in SEND until it falls.
  - All requesters valid continuously: owners rotate 0,1,2,3,0...
  - Requester drops valid between IDLE sample and grant: it keeps the grant and the timeout applies.
  - Non-owner req_ready is always 0; non-owner inputs are ignored.
  - Reset mid-packet: arbiter returns to IDLE immediately; any uart frame in progress finishes on its own.
  - The re-arbitration gap after a packet is the IDLE cycle, so another requester can win at most 1 cycle after HOLD.

Decomposition:
- Shared header uart_arb_defs.vh holds the state encoding localparams (S_IDLE=0, S_SEND=1, S_HOLD=2) and the index width constant.
- One natural combinational sub-module: rr_pick (inputs req vector and pointer; outputs one-hot winner, winner index and any flag). It is reused by other arbiters in the design.

Test Plan:
1. Single requester 0 sends packet 0x48,0x69(last) through the real uart model (CLK_FREQ=16, BIT_FREQ=3) in loopback:
   - uart rx yields 0x48 then 0x69.
   - grant=0001 during the packet, 0 afterwards.
   - uart_wr pulses exactly twice.
2. Requesters 0 and 2 both valid at reset release; req0 sends 3 bytes 0xA0..0xA2, req2 sends 2 bytes 0xC0,0xC1:
   - Output order is A0,A1,A2,C0,C1 with no interleaving.
   - grant goes 0001 then 0100.
3. All 4 requesters assert single-byte packets continuously for 12 packets:
   - Owner sequence 0,1,2,3 repeated three times.
   - Pointer wraps correctly.
4. uart_busy forced high for 50 cycles while req1 is valid:
   - uart_wr stays 0 and req_ready stays 0.
   - No evict with TIMEOUT=16.
   - Byte is accepted in the first cycle busy=0.
5. TIMEOUT=16, req3 sends one non-last byte, then drops valid:
   - evict=1 and evict_id=3 exactly 16 SEND cycles after HOLD.
   - grant=0 the next cycle; waiting req0 is granted 1 cycle later.
6. rst_n asserted mid-packet (after 1 of 3 bytes):
   - grant, evict and uart_wr go 0 immediately.
   - After release, a new request from req2 is granted with pointer restarted at 0.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the uart transmit arbiter: FSM encoding and evict id width.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_HOLD = 2'd2
    } arb_state_e;

    // evict_id is a fixed 3-bit field so N_REQ can go up to 8.
    localparam int EVICT_IDW = 3;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above the pointer, with wrap.
// Purely combinational so other arbiters can reuse it.
module rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Rotating scan starting at ptr_i; the first hit wins.
    always_comb begin
        int j;
        any_o    = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        j        = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_i) + i;
            if (j >= N) j = j - N;
            if (!any_o && req_i[j]) begin
                any_o = 1'b1;
                idx_o = IW'(j);
            end
        end
        if (any_o) onehot_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart transmitter between N_REQ packet sources. Grants are
// round-robin and held for a whole packet; a stalled owner is evicted
// after TIMEOUT cycles without offering a byte.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1023,
    parameter int TW      = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [8*N_REQ-1:0]     req_data,
    input  logic [N_REQ-1:0]       req_last,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       grant,
    output logic [7:0]             uart_data,
    output logic                   uart_wr,
    input  logic                   uart_busy,
    output logic                   evict,
    output logic [EVICT_IDW-1:0]   evict_id
);

    localparam int IW = $clog2(N_REQ);

    arb_state_e           state_q;
    logic [N_REQ-1:0]     grant_q;
    logic [IW-1:0]        owner_q;
    logic [IW-1:0]        ptr_q;
    logic [IW-1:0]        ptr_d;
    logic [TW-1:0]        cnt_q;
    logic                 last_q;
    logic                 evict_q;
    logic [EVICT_IDW-1:0] evict_id_q;

    logic [N_REQ-1:0]     win_oh;
    logic [IW-1:0]        win_idx;
    logic                 win_any;
    logic                 own_valid;
    logic                 acc;
    logic                 tmo_hit;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req_i    (req_valid),
        .ptr_i    (ptr_q),
        .onehot_o (win_oh),
        .idx_o    (win_idx),
        .any_o    (win_any)
    );

    // Pointer moves one past the winner so the winner goes to the back of the line.
    assign ptr_d = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + IW'(1);

    assign own_valid = req_valid[owner_q];
    // A byte moves only when the owner offers it and the uart can take it.
    assign acc       = (state_q == S_SEND) && own_valid && !uart_busy;
    // Only cycles with no byte offered count towards eviction.
    assign tmo_hit   = (TIMEOUT != 0) && !own_valid && (int'(cnt_q) == TIMEOUT - 1);

    assign uart_wr   = acc;
    assign req_ready = acc ? grant_q : '0;
    assign uart_data = (state_q == S_IDLE) ? 8'h00 : req_data[{owner_q, 3'b000} +: 8];
    assign grant     = grant_q;
    assign evict     = evict_q;
    assign evict_id  = evict_id_q;

    // Arbitration FSM: IDLE picks an owner, SEND waits for a byte, HOLD spaces strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            evict_q    <= 1'b0;
            evict_id_q <= '0;
        end else begin
            evict_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (win_any) begin
                        grant_q <= win_oh;
                        owner_q <= win_idx;
                        ptr_q   <= ptr_d;
                        cnt_q   <= '0;
                        state_q <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (acc) begin
                        last_q  <= req_last[owner_q];
                        cnt_q   <= '0;
                        state_q <= S_HOLD;
                    end else if (tmo_hit) begin
                        evict_q    <= 1'b1;
                        evict_id_q <= EVICT_IDW'(owner_q);
                        grant_q    <= '0;
                        cnt_q      <= '0;
                        state_q    <= S_IDLE;
                    end else if ((TIMEOUT != 0) && !own_valid) begin
                        cnt_q <= cnt_q + TW'(1);
                    end
                end
                S_HOLD: begin
                    if (last_q) begin
                        grant_q <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_SEND;
                    end
                end
                default: begin
                    grant_q <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a cycle table plus hand sequences for
// packet ordering, rotation, busy stalls, eviction and mid-packet reset.
module tb_uart_tx_arbiter;

    localparam int N        = 4;
    localparam int BUSY_LEN = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]  req_last = '0;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  grant;
    logic [7:0]    uart_data;
    logic          uart_wr;
    logic          uart_busy = 1'b0;
    logic          evict;
    logic [2:0]    evict_id;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(16), .TW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .uart_data (uart_data),
        .uart_wr   (uart_wr),
        .uart_busy (uart_busy),
        .evict     (evict),
        .evict_id  (evict_id)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic [3:0] v;
        logic [3:0] l;
        logic       b;
        logic [3:0] g;
        logic [3:0] r;
        logic       w;
        logic [7:0] d;
    } vec_t;

    vec_t tbl[15];

    // packet sources for multi-byte sequences
    logic [7:0] sb[N][12];
    bit         sl[N][12];
    int         slen[N];
    int         spos[N];
    logic [7:0] rx_q[$];
    logic [3:0] own_q[$];
    int         wr_cnt;
    int         b2b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] v, input logic [3:0] l, input logic b);
        @(posedge clk); #1;
        req_valid = v;
        req_last  = l;
        uart_busy = b;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        req_valid = '0; req_last = '0; uart_busy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_wr", uart_wr, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_evict", {evict, evict_id}, 0);
        chk("rst_data", uart_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic clr_src();
        for (int i = 0; i < N; i++) begin
            slen[i] = 0;
            spos[i] = 0;
        end
        rx_q.delete();
        own_q.delete();
        wr_cnt = 0;
        b2b = 0;
    endtask

    // Drives the sources and a simple busy model until all bytes are out and
    // the grant has dropped, or the cycle budget runs out.
    task automatic run_src(input string name, input int budget);
        int  busy_cnt = 0;
        bit  prev_wr = 0;
        bit  done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (spos[i] < slen[i]) begin
                    req_valid[i] = 1'b1;
                    req_last[i]  = sl[i][spos[i]];
                    req_data[8*i +: 8] = sb[i][spos[i]];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                end
            end
            uart_busy = (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
            @(negedge clk);
            if (uart_wr && !uart_busy) begin
                rx_q.push_back(uart_data);
                own_q.push_back(grant);
                wr_cnt++;
                if (prev_wr) b2b++;
                busy_cnt = BUSY_LEN;
            end
            prev_wr = uart_wr;
            for (int i = 0; i < N; i++)
                if (req_ready[i]) spos[i]++;
            done = (grant == 0);
            for (int i = 0; i < N; i++)
                if (spos[i] < slen[i]) done = 0;
        end
        chk({name, "_done"}, done, 1);
    endtask

    initial begin
        tbl[0]  = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00};
        tbl[1]  = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0000, 1'b0, 8'hA0};
        tbl[2]  = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA0};
        tbl[3]  = '{4'b0101, 4'b0000, 1'b1, 4'b0001, 4'b0000, 1'b0, 8'hA0};
        tbl[4]  = '{4'b0101, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00};
        tbl[5]  = '{4'b0101, 4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'hC2};
        tbl[6]  = '{4'b0101, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0, 8'hC2};
        tbl[7]  = '{4'b0101, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00};
        tbl[8]  = '{4'b0111, 4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA0};
        tbl[9]  = '{4'b0111, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0, 8'hA0};
        tbl[10] = '{4'b0110, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0, 8'hA0};
        tbl[11] = '{4'b0111, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA0};
        tbl[12] = '{4'b0110, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0, 8'hA0};
        tbl[13] = '{4'b0110, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00};
        tbl[14] = '{4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b0, 8'hB1};

        // cycle table
        do_reset();
        req_data = 32'hD3C2B1A0;
        for (int k = 0; k < 15; k++) begin
            cyc(tbl[k].v, tbl[k].l, tbl[k].b);
            chk($sformatf("tbl%0d_grant", k), grant, tbl[k].g);
            chk($sformatf("tbl%0d_ready", k), req_ready, tbl[k].r);
            chk($sformatf("tbl%0d_wr", k), uart_wr, tbl[k].w);
            chk($sformatf("tbl%0d_data", k), uart_data, tbl[k].d);
        end

        // single two-byte packet from req0
        do_reset();
        clr_src();
        sb[0][0] = 8'h48; sl[0][0] = 0;
        sb[0][1] = 8'h69; sl[0][1] = 1;
        slen[0] = 2;
        run_src("t1", 200);
        chk("t1_wrcnt", wr_cnt, 2);
        if (wr_cnt == 2) begin
            chk("t1_b0", rx_q[0], 8'h48);
            chk("t1_b1", rx_q[1], 8'h69);
            chk("t1_g0", own_q[0], 4'b0001);
            chk("t1_g1", own_q[1], 4'b0001);
        end
        chk("t1_grant_end", grant, 0);

        // req0 and req2 contend, packets must not interleave
        do_reset();
        clr_src();
        for (int k = 0; k < 3; k++) begin sb[0][k] = 8'hA0 + 8'(k); sl[0][k] = (k == 2); end
        for (int k = 0; k < 2; k++) begin sb[2][k] = 8'hC0 + 8'(k); sl[2][k] = (k == 1); end
        slen[0] = 3; slen[2] = 2;
        run_src("t2", 300);
        chk("t2_wrcnt", wr_cnt, 5);
        if (wr_cnt == 5) begin
            logic [7:0] eb[5];
            logic [3:0] eg[5];
            eb = '{8'hA0, 8'hA1, 8'hA2, 8'hC0, 8'hC1};
            eg = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100};
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("t2_byte%0d", k), rx_q[k], eb[k]);
                chk($sformatf("t2_grant%0d", k), own_q[k], eg[k]);
            end
        end
        chk("t2_b2b", b2b, 0);

        // all four requesters, single-byte packets, rotation with wrap
        do_reset();
        clr_src();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 3; k++) begin
                sb[i][k] = 8'(16 * i + k);
                sl[i][k] = 1;
            end
            slen[i] = 3;
        end
        run_src("t3", 500);
        chk("t3_wrcnt", wr_cnt, 12);
        if (wr_cnt == 12) begin
            for (int k = 0; k < 12; k++) begin
                logic [3:0] eo;
                eo = 4'b0001 << (k % 4);
                chk($sformatf("t3_owner%0d", k), own_q[k], eo);
            end
        end
        chk("t3_b2b", b2b, 0);

        // busy held high: owner waits, never evicted
        do_reset();
        req_data = 32'hD3C2B1A0;
        begin
            int bad = 0;
            for (int k = 0; k < 50; k++) begin
                cyc(4'b0010, 4'b0010, 1'b1);
                if (uart_wr || req_ready != 0 || evict) bad++;
            end
            chk("t4_stall_quiet", bad, 0);
            chk("t4_grant", grant, 4'b0010);
        end
        cyc(4'b0010, 4'b0010, 1'b0);
        chk("t4_wr", uart_wr, 1);
        chk("t4_ready", req_ready, 4'b0010);
        chk("t4_data", uart_data, 8'hB1);

        // timeout eviction of req3, req0 waiting
        do_reset();
        req_data = 32'hD3C2B1A0;
        cyc(4'b1000, 4'b0000, 1'b0);
        cyc(4'b1000, 4'b0000, 1'b0);
        chk("t5_wr", uart_wr, 1);
        cyc(4'b0001, 4'b0000, 1'b0);
        chk("t5_hold", uart_wr, 0);
        begin
            int bad = 0;
            for (int k = 0; k < 16; k++) begin
                cyc(4'b0001, 4'b0000, 1'b0);
                if (evict || grant != 4'b1000) bad++;
            end
            chk("t5_pre_evict", bad, 0);
        end
        cyc(4'b0001, 4'b0000, 1'b0);
        chk("t5_evict", evict, 1);
        chk("t5_evict_id", evict_id, 3);
        chk("t5_grant0", grant, 0);
        cyc(4'b0001, 4'b0000, 1'b0);
        chk("t5_evict_pulse", evict, 0);
        chk("t5_regrant", grant, 4'b0001);

        // reset mid-packet, pointer restarts at 0
        do_reset();
        req_data = 32'hD3C2B1A0;
        cyc(4'b0100, 4'b0000, 1'b0);
        cyc(4'b0100, 4'b0000, 1'b0);
        cyc(4'b0100, 4'b0000, 1'b0);
        cyc(4'b0100, 4'b0000, 1'b0);
        chk("t6_wr_before", uart_wr, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_grant_rst", grant, 0);
        chk("t6_wr_rst", uart_wr, 0);
        chk("t6_ready_rst", req_ready, 0);
        chk("t6_evict_rst", evict, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid = 4'b1100;
        cyc(4'b1100, 4'b0000, 1'b0);
        chk("t6_regrant", grant, 4'b0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
